// File: rtl/contador_pkg.sv
// -----------------------------------------------------------------------------
// contador_pkg
// Shared definitions for the contador event-capture path.
//   DEF_WIDTH  : default width of the counter value Q
//   KIND_*     : event tag stored alongside each captured counter value
//   entry_t    : packed capture entry {kind, value} at the default width
//   encode_kind: maps the two rising-edge strobes onto an event tag
// -----------------------------------------------------------------------------
package contador_pkg;

    localparam int DEF_WIDTH = 4;

    localparam logic [1:0] KIND_NONE = 2'b00;
    localparam logic [1:0] KIND_RCO  = 2'b01;
    localparam logic [1:0] KIND_LOAD = 2'b10;
    localparam logic [1:0] KIND_BOTH = 2'b11;

    typedef struct packed {
        logic [1:0]           kind;
        logic [DEF_WIDTH-1:0] value;
    } entry_t;

    // KIND_NONE is only returned when neither edge fired; it is never stored.
    function automatic logic [1:0] encode_kind(input logic rco_rise, input logic load_rise);
        logic [1:0] kind;
        case ({rco_rise, load_rise})
            2'b10:   kind = KIND_RCO;
            2'b01:   kind = KIND_LOAD;
            2'b11:   kind = KIND_BOTH;
            default: kind = KIND_NONE;
        endcase
        return kind;
    endfunction

endpackage

// File: rtl/fifo_sinc.sv
// -----------------------------------------------------------------------------
// fifo_sinc
// Generic single-clock FIFO with a registered head-of-queue output.
//   clk    in  : clock, rising edge
//   reset  in  : synchronous active-high reset
//   clear  in  : synchronous soft clear; discards any push/pop that cycle
//   push   in  : write din (ignored when full unless a pop happens too)
//   din    in  : WIDTH-bit write data
//   pop    in  : remove head entry (ignored when empty)
//   dout   out : head entry, registered; 0 whenever the FIFO is empty
//   level  out : number of occupied entries
//   full   out : level == DEPTH
//   empty  out : level == 0
// -----------------------------------------------------------------------------
module fifo_sinc #(
    parameter int WIDTH = 6,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [LW-1:0] LVL_ONE  = LW'(1);
    localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [LW-1:0]    level_r;
    logic             full_r;
    logic             empty_r;
    logic [WIDTH-1:0] dout_r;

    logic [AW-1:0]    wr_ptr_nxt_s;
    logic [AW-1:0]    rd_ptr_nxt_s;
    logic [LW-1:0]    level_nxt_s;
    logic [WIDTH-1:0] dout_nxt_s;
    logic             do_push_s;
    logic             do_pop_s;

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_pop_s  = pop & ~empty_r & ~clear;
    assign do_push_s = push & ~clear & (~full_r | do_pop_s);

    // Next pointers, occupancy and the head value visible after this edge.
    always_comb begin
        wr_ptr_nxt_s = wr_ptr_r;
        rd_ptr_nxt_s = rd_ptr_r;
        level_nxt_s  = level_r;
        dout_nxt_s   = {WIDTH{1'b0}};

        if (clear) begin
            wr_ptr_nxt_s = {AW{1'b0}};
            rd_ptr_nxt_s = {AW{1'b0}};
            level_nxt_s  = {LW{1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_nxt_s = wr_ptr_r + PTR_ONE;
            end else begin
                wr_ptr_nxt_s = wr_ptr_r;
            end
            if (do_pop_s) begin
                rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
            end else begin
                rd_ptr_nxt_s = rd_ptr_r;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   level_nxt_s = level_r + LVL_ONE;
                2'b01:   level_nxt_s = level_r - LVL_ONE;
                default: level_nxt_s = level_r;
            endcase
        end

        // The new head is the entry being written now if it lands exactly at
        // the next read pointer (push into an empty FIFO), otherwise storage.
        if (level_nxt_s == {LW{1'b0}}) begin
            dout_nxt_s = {WIDTH{1'b0}};
        end else if (do_push_s && (wr_ptr_r == rd_ptr_nxt_s)) begin
            dout_nxt_s = din;
        end else begin
            dout_nxt_s = mem_r[rd_ptr_nxt_s];
        end
    end

    // Control state and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            level_r  <= {LW{1'b0}};
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
            dout_r   <= {WIDTH{1'b0}};
        end else begin
            wr_ptr_r <= wr_ptr_nxt_s;
            rd_ptr_r <= rd_ptr_nxt_s;
            level_r  <= level_nxt_s;
            full_r   <= (level_nxt_s == LVL_FULL);
            empty_r  <= (level_nxt_s == {LW{1'b0}});
            dout_r   <= dout_nxt_s;
        end
    end

    // Entry storage; contents need no reset since they are only read when occupied.
    always_ff @(posedge clk) begin
        if (!reset && do_push_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    assign dout  = dout_r;
    assign level = level_r;
    assign full  = full_r;
    assign empty = empty_r;

endmodule

// File: rtl/captura_contador.sv
// -----------------------------------------------------------------------------
// captura_contador
// Captures rising edges of the contador rco/load outputs together with the
// counter value into a small FIFO drained through a valid/ready port.
//   clk       in  : clock, rising edge
//   reset     in  : synchronous active-high reset, overrides everything
//   Q         in  : counter value (WIDTH bits)
//   rco       in  : counter terminal-count output
//   load      in  : counter load indication
//   clear     in  : soft clear of FIFO, ovf and rco_count
//   rd_ready  in  : consumer takes the head entry this cycle
//   rd_valid  out : head entry valid
//   rd_data   out : head entry {kind[1:0], value[WIDTH-1:0]}
//   level     out : occupied entries
//   empty     out : level == 0
//   full      out : level == DEPTH
//   ovf       out : sticky, an event was dropped on a full FIFO
//   rco_count out : saturating count of rco rising edges
// -----------------------------------------------------------------------------
module captura_contador
    import contador_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = 4,
    parameter int EVW   = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [WIDTH-1:0]       Q,
    input  logic                   rco,
    input  logic                   load,
    input  logic                   clear,
    input  logic                   rd_ready,
    output logic                   rd_valid,
    output logic [WIDTH+1:0]       rd_data,
    output logic [$clog2(DEPTH):0] level,
    output logic                   empty,
    output logic                   full,
    output logic                   ovf,
    output logic [EVW-1:0]         rco_count
);

    localparam logic [EVW-1:0] CNT_ONE = EVW'(1);
    localparam logic [EVW-1:0] CNT_MAX = {EVW{1'b1}};

    logic           rco_q_r;
    logic           load_q_r;
    logic           ovf_r;
    logic [EVW-1:0] rco_count_r;

    logic             rco_rise_s;
    logic             load_rise_s;
    logic             ev_s;
    logic [1:0]       kind_s;
    logic [WIDTH+1:0] entry_s;
    logic             full_s;
    logic             empty_s;
    logic             ovf_set_s;

    assign rco_rise_s  = rco & ~rco_q_r;
    assign load_rise_s = load & ~load_q_r;
    assign ev_s        = rco_rise_s | load_rise_s;
    assign kind_s      = encode_kind(rco_rise_s, load_rise_s);
    assign entry_s     = {kind_s, Q};

    // A full FIFO is never empty, so rd_ready alone decides whether a pop
    // frees a slot for the incoming event.
    assign ovf_set_s = ev_s & full_s & ~rd_ready & ~clear;

    // Edge-detect history; clear leaves it running so a held level does not re-fire.
    always_ff @(posedge clk) begin
        if (reset) begin
            rco_q_r  <= 1'b0;
            load_q_r <= 1'b0;
        end else begin
            rco_q_r  <= rco;
            load_q_r <= load;
        end
    end

    // Sticky overflow flag.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            ovf_r <= 1'b0;
        end else if (ovf_set_s) begin
            ovf_r <= 1'b1;
        end else begin
            ovf_r <= ovf_r;
        end
    end

    // Saturating rco edge counter; counts edges even when the entry is dropped.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            rco_count_r <= {EVW{1'b0}};
        end else if (rco_rise_s && (rco_count_r != CNT_MAX)) begin
            rco_count_r <= rco_count_r + CNT_ONE;
        end else begin
            rco_count_r <= rco_count_r;
        end
    end

    fifo_sinc #(
        .WIDTH (WIDTH + 2),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .push  (ev_s),
        .din   (entry_s),
        .pop   (rd_ready),
        .dout  (rd_data),
        .level (level),
        .full  (full_s),
        .empty (empty_s)
    );

    assign rd_valid  = ~empty_s;
    assign empty     = empty_s;
    assign full      = full_s;
    assign ovf       = ovf_r;
    assign rco_count = rco_count_r;

endmodule
